weight_load_scheduler: RTL and testbench
========================================

// Module: weight_load_scheduler
// PURPOSE
//  Sequences the encrypted-weight loader. Arbitrates model-switch requests (A/B), drains in-flight
//  inference, drives the loader start/model/key handshake, watches for a hung load, and gates BNN
//  inference grants so the BNN never reads weight RAM while it is being rewritten.
// PARAMETERS
//  TIMEOUT_CYCLES  4096  max cycles in WAIT_DONE before a load is declared hung
//  TW              13    width of timeout counter; must satisfy 2**TW > TIMEOUT_CYCLES
// PORTS
//  clk            in   1  single clock, all logic on posedge
//  rst            in   1  synchronous, active-low reset
//  req_a          in   1  pulse: request switch to Model A
//  req_b          in   1  pulse: request switch to Model B
//  key_in         in   8  decryption key, sampled when a request is accepted
//  clear_err      in   1  pulse: clears err_timeout
//  infer_req      in   1  level: BNN requests weight access
//  infer_busy     in   1  level: BNN inference in flight
//  done_loading   in   1  from loader: high in its DONE state until start drops
//  load_start     out  1  to loader: held high from START until done_loading seen
//  loader_model   out  2  to loader: 2'b01 Model A, 2'b10 Model B
//  loader_key     out  8  to loader: latched key, stable for whole load
//  infer_grant    out  1  BNN may read weight RAM
//  active_model   out  2  model currently resident (2'b00 none)
//  weights_valid  out  1  resident weights are complete and usable
//  busy           out  1  high in any state except IDLE
//  err_timeout    out  1  sticky: last load hung
// BEHAVIOUR
//  Reset (rst==0 at posedge): all outputs 0, state IDLE, pend_a/pend_b/rr_last cleared. Applies
//   mid-load too; load_start drops next cycle, weights_valid stays 0 until a full reload.
//  Requests: req_a/req_b set sticky pend_a/pend_b. A request for the model already resident with
//   weights_valid==1 is discarded. Pend set and served in the same cycle: set wins, request re-served.
//  Arbitration (IDLE only): one pending -> serve it; both -> round-robin, other than rr_last
//   (rr_last reset = B, so A wins the first tie). Selected pend bit cleared; key_in -> loader_key;
//   loader_model set; rr_last updated.
//  infer_grant: registered. Rises in IDLE when infer_req && weights_valid && no pend bit set;
//   falls cycle after infer_req drops, or on leaving IDLE. Pending request blocks new grants.
//  FSM:
//   IDLE      -> DRAIN when a request is selected (grant dropped).
//   DRAIN     wait infer_busy==0 && infer_grant==0; weights_valid<=0, active_model<=0; -> START.
//   START     load_start<=1, timer<=0; -> WAIT_DONE.
//   WAIT_DONE load_start held 1, timer++. done_loading==1 -> active_model<=loader_model,
//             weights_valid<=1, -> RELEASE. timer==TIMEOUT_CYCLES-1 -> err_timeout<=1, -> RELEASE.
//   RELEASE   load_start<=0; wait done_loading==0 (loader back in IDLE); -> IDLE.
//  Latency: request pulse to load_start high = 3 cycles with BNN idle (IDLE,DRAIN,START).
//  done_loading and timeout same cycle: done wins, no error.
//  clear_err and new timeout same cycle: set wins.
//  loader_model/loader_key change only at arbitration; stable through WAIT_DONE/RELEASE.
//  Requests arriving during a load stay pending; served on return to IDLE.
// TESTING
//  1 Reset, pulse req_a, key_in=8'h5A; model done_loading 20 cycles after load_start -> load_start
//    high 3 cycles after req, loader_model=01, loader_key=5A, then active_model=01, weights_valid=1.
//  2 req_a and req_b same cycle from reset -> A served first, B auto-served after RELEASE;
//    final active_model=10; load_start pulses twice.
//  3 Model A resident, infer_busy=1 for 50 cycles, pulse req_b -> stays in DRAIN 50 cycles,
//    infer_grant 0, load_start rises 2 cycles after infer_busy falls.
//  4 TIMEOUT_CYCLES=16, done_loading never rises -> err_timeout=1 after 16 cycles in WAIT_DONE,
//    weights_valid=0, active_model=00; clear_err clears it.
//  5 Model A resident, pulse req_a -> discarded, busy stays 0; infer_req=1 -> grant next cycle.
//  6 rst low mid-WAIT_DONE -> next cycle all outputs 0, state IDLE, pend bits cleared.

Source files
------------

// File: rtl/weight_load_scheduler.sv
// rtl/weight_load_scheduler.sv - encrypted-weight load sequencer with A/B arbitration and BNN grant gating
module weight_load_scheduler #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TW             = 13
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_a,
  input  logic       req_b,
  input  logic [7:0] key_in,
  input  logic       clear_err,
  input  logic       infer_req,
  input  logic       infer_busy,
  input  logic       done_loading,
  output logic       load_start,
  output logic [1:0] loader_model,
  output logic [7:0] loader_key,
  output logic       infer_grant,
  output logic [1:0] active_model,
  output logic       weights_valid,
  output logic       busy,
  output logic       err_timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_START,
    S_WAIT_DONE,
    S_RELEASE
  } state_t;

  localparam logic [1:0]    MODEL_A    = 2'b01;
  localparam logic [1:0]    MODEL_B    = 2'b10;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t        state_q, state_d;
  logic          pend_a_q, pend_a_d;
  logic          pend_b_q, pend_b_d;
  logic          rr_last_a_q, rr_last_a_d;
  logic          load_start_q, load_start_d;
  logic [1:0]    loader_model_q, loader_model_d;
  logic [7:0]    loader_key_q, loader_key_d;
  logic          infer_grant_q, infer_grant_d;
  logic [1:0]    active_model_q, active_model_d;
  logic          weights_valid_q, weights_valid_d;
  logic          err_timeout_q, err_timeout_d;
  logic [TW-1:0] timer_q, timer_d;

  logic acc_a, acc_b, want_a, want_b, sel_a, sel_b, err_set;

  always_comb begin
    state_d         = state_q;
    rr_last_a_d     = rr_last_a_q;
    load_start_d    = load_start_q;
    loader_model_d  = loader_model_q;
    loader_key_d    = loader_key_q;
    active_model_d  = active_model_q;
    weights_valid_d = weights_valid_q;
    timer_d         = timer_q;
    err_set         = 1'b0;
    sel_a           = 1'b0;
    sel_b           = 1'b0;

    // A request for the model that is already resident and valid is dropped
    acc_a  = req_a && !(weights_valid_q && (active_model_q == MODEL_A));
    acc_b  = req_b && !(weights_valid_q && (active_model_q == MODEL_B));
    want_a = pend_a_q || acc_a;
    want_b = pend_b_q || acc_b;

    if (state_q == S_IDLE) begin
      if (want_a && want_b) begin
        sel_a = !rr_last_a_q;
        sel_b = rr_last_a_q;
      end else begin
        sel_a = want_a;
        sel_b = want_b;
      end
    end

    // A fresh pulse on an already-pending bit that is being served re-arms it
    pend_a_d = (pend_a_q && !sel_a) || (acc_a && !(sel_a && !pend_a_q));
    pend_b_d = (pend_b_q && !sel_b) || (acc_b && !(sel_b && !pend_b_q));

    case (state_q)
      S_IDLE: begin
        if (sel_a || sel_b) begin
          state_d        = S_DRAIN;
          loader_model_d = sel_a ? MODEL_A : MODEL_B;
          loader_key_d   = key_in;
          rr_last_a_d    = sel_a;
        end
      end
      S_DRAIN: begin
        weights_valid_d = 1'b0;
        active_model_d  = 2'b00;
        if (!infer_busy && !infer_grant_q) state_d = S_START;
      end
      S_START: begin
        load_start_d = 1'b1;
        timer_d      = '0;
        state_d      = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        timer_d = timer_q + 1'b1;
        if (done_loading) begin
          active_model_d  = loader_model_q;
          weights_valid_d = 1'b1;
          state_d         = S_RELEASE;
        end else if (timer_q == TIMER_LAST) begin
          err_set = 1'b1;
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        load_start_d = 1'b0;
        if (!done_loading) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    err_timeout_d = err_set ? 1'b1 : (clear_err ? 1'b0 : err_timeout_q);
    infer_grant_d = (state_q == S_IDLE) && !(sel_a || sel_b) && infer_req && weights_valid_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q         <= S_IDLE;
      pend_a_q        <= 1'b0;
      pend_b_q        <= 1'b0;
      rr_last_a_q     <= 1'b0;
      load_start_q    <= 1'b0;
      loader_model_q  <= 2'b00;
      loader_key_q    <= 8'h00;
      infer_grant_q   <= 1'b0;
      active_model_q  <= 2'b00;
      weights_valid_q <= 1'b0;
      err_timeout_q   <= 1'b0;
      timer_q         <= '0;
    end else begin
      state_q         <= state_d;
      pend_a_q        <= pend_a_d;
      pend_b_q        <= pend_b_d;
      rr_last_a_q     <= rr_last_a_d;
      load_start_q    <= load_start_d;
      loader_model_q  <= loader_model_d;
      loader_key_q    <= loader_key_d;
      infer_grant_q   <= infer_grant_d;
      active_model_q  <= active_model_d;
      weights_valid_q <= weights_valid_d;
      err_timeout_q   <= err_timeout_d;
      timer_q         <= timer_d;
    end
  end

  assign load_start    = load_start_q;
  assign loader_model  = loader_model_q;
  assign loader_key    = loader_key_q;
  assign infer_grant   = infer_grant_q;
  assign active_model  = active_model_q;
  assign weights_valid = weights_valid_q;
  assign busy          = (state_q != S_IDLE);
  assign err_timeout   = err_timeout_q;

endmodule

// File: tb/tb_weight_load_scheduler.sv
// tb/tb_weight_load_scheduler.sv - directed scoreboard bench for weight_load_scheduler
module tb_weight_load_scheduler;

  localparam int TO  = 32;
  localparam int TWB = 6;

  logic       clk = 1'b0;
  logic       rst, req_a, req_b, clear_err, infer_req, infer_busy;
  logic       done_loading = 1'b0;
  logic [7:0] key_in;
  logic       load_start, infer_grant, weights_valid, busy, err_timeout;
  logic [1:0] loader_model, active_model;
  logic [7:0] loader_key;

  int         n_vec = 0;
  int         n_err = 0;
  logic [9:0] exp_q[$];
  int         ld_delay = 20;
  bit         ld_en = 1'b1;
  int         ld_cnt = 0;
  int         start_cnt = 0;
  logic       ls_prev = 1'b0;

  always #5 clk = ~clk;

  weight_load_scheduler #(.TIMEOUT_CYCLES(TO), .TW(TWB)) dut (
    .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b), .key_in(key_in),
    .clear_err(clear_err), .infer_req(infer_req), .infer_busy(infer_busy),
    .done_loading(done_loading), .load_start(load_start), .loader_model(loader_model),
    .loader_key(loader_key), .infer_grant(infer_grant), .active_model(active_model),
    .weights_valid(weights_valid), .busy(busy), .err_timeout(err_timeout)
  );

  // Loader model: raise done ld_delay cycles after start, hold until start drops
  always @(posedge clk) begin
    if (!rst || !load_start) begin
      done_loading <= 1'b0;
      ld_cnt       <= 0;
    end else if (!done_loading) begin
      ld_cnt <= ld_cnt + 1;
      if (ld_en && ld_cnt == ld_delay - 1) done_loading <= 1'b1;
    end
  end

  always @(posedge clk) begin
    ls_prev <= load_start;
    if (load_start && !ls_prev) start_cnt <= start_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic req_pulse(input logic a, input logic b, input logic [7:0] k, input bit push);
    req_a  = a;
    req_b  = b;
    key_in = k;
    if (push && a) exp_q.push_back({2'b01, k});
    if (push && b) exp_q.push_back({2'b10, k});
  endtask

  task automatic wait_start(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      req_a = 1'b0;
      req_b = 1'b0;
      cyc++;
    end while (!load_start && cyc < 300);
  endtask

  task automatic wait_low();
    int n = 0;
    while (load_start && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("load_start_fall_bound", load_start, 1'b0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("idle_bound", busy, 1'b0);
  endtask

  task automatic pop_check(input string tag);
    logic [9:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_nonempty"}, 0, 1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_model"}, loader_model, e[9:8]);
      check({tag, "_key"}, loader_key, e[7:0]);
    end
  endtask

  initial begin
    int  cyc;
    int  s0;
    bit  flag;
    rst = 1'b0; req_a = 1'b0; req_b = 1'b0; key_in = 8'h00;
    clear_err = 1'b0; infer_req = 1'b0; infer_busy = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_load_start", load_start, 0);
    check("rst_loader_model", loader_model, 0);
    check("rst_loader_key", loader_key, 0);
    check("rst_grant", infer_grant, 0);
    check("rst_active", active_model, 0);
    check("rst_valid", weights_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err_timeout, 0);
    rst = 1'b1;
    @(negedge clk);

    // single load of A
    req_pulse(1'b1, 1'b0, 8'h5A, 1'b1);
    wait_start(cyc);
    check("t1_latency", cyc, 3);
    pop_check("t1");
    wait_idle();
    check("t1_active", active_model, 2'b01);
    check("t1_valid", weights_valid, 1);
    check("t1_err", err_timeout, 0);

    // simultaneous A/B from reset
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    ld_delay = 5;
    s0 = start_cnt;
    req_pulse(1'b1, 1'b1, 8'h33, 1'b1);
    wait_start(cyc);
    check("t2_latency", cyc, 3);
    pop_check("t2_first");
    wait_low();
    wait_start(cyc);
    check("t2_second_started", load_start, 1);
    pop_check("t2_second");
    wait_idle();
    check("t2_active", active_model, 2'b10);
    check("t2_valid", weights_valid, 1);
    check("t2_starts", start_cnt - s0, 2);

    // drain behind busy BNN
    req_pulse(1'b1, 1'b0, 8'hC3, 1'b1);
    wait_start(cyc);
    pop_check("t3_reload_a");
    wait_idle();
    check("t3_active_a", active_model, 2'b01);
    infer_busy = 1'b1;
    infer_req  = 1'b1;
    @(negedge clk);
    check("t3_grant_up", infer_grant, 1);
    req_pulse(1'b0, 1'b1, 8'h7E, 1'b1);
    flag = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      req_a = 1'b0;
      req_b = 1'b0;
      if (load_start || infer_grant || !busy) flag = 1'b0;
    end
    check("t3_held_in_drain", flag, 1);
    infer_busy = 1'b0;
    infer_req  = 1'b0;
    wait_start(cyc);
    check("t3_latency_after_busy", cyc, 2);
    pop_check("t3");
    wait_idle();
    check("t3_active_b", active_model, 2'b10);

    // duplicate request discarded, grant follows infer_req
    req_pulse(1'b1, 1'b0, 8'h11, 1'b1);
    wait_start(cyc);
    pop_check("t5_load_a");
    wait_idle();
    req_pulse(1'b1, 1'b0, 8'h99, 1'b0);
    flag = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      req_a = 1'b0;
      if (busy || load_start) flag = 1'b1;
    end
    check("t5_discard_busy", flag, 0);
    check("t5_key_unchanged", loader_key, 8'h11);
    infer_req = 1'b1;
    @(negedge clk);
    check("t5_grant_rise", infer_grant, 1);
    infer_req = 1'b0;
    @(negedge clk);
    check("t5_grant_fall", infer_grant, 0);

    // hung loader
    ld_en = 1'b0;
    req_pulse(1'b0, 1'b1, 8'hE4, 1'b1);
    wait_start(cyc);
    check("t4_latency", cyc, 3);
    pop_check("t4");
    cyc = 0;
    while (!err_timeout && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    check("t4_timeout_cycles", cyc, TO);
    check("t4_valid", weights_valid, 0);
    check("t4_active", active_model, 0);
    wait_idle();
    check("t4_load_start_low", load_start, 0);
    check("t4_err_sticky", err_timeout, 1);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    check("t4_err_cleared", err_timeout, 0);

    // reset mid-WAIT_DONE with a request pending
    ld_en = 1'b1;
    ld_delay = 20;
    req_pulse(1'b1, 1'b0, 8'h42, 1'b0);
    wait_start(cyc);
    repeat (4) @(negedge clk);
    req_pulse(1'b0, 1'b1, 8'h43, 1'b0);
    @(negedge clk);
    req_b = 1'b0;
    rst   = 1'b0;
    @(negedge clk);
    check("t6_load_start", load_start, 0);
    check("t6_model", loader_model, 0);
    check("t6_key", loader_key, 0);
    check("t6_active", active_model, 0);
    check("t6_valid", weights_valid, 0);
    check("t6_busy", busy, 0);
    rst  = 1'b1;
    flag = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (busy || load_start) flag = 1'b1;
    end
    check("t6_pend_cleared", flag, 0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
